// File: rtl/tune_player.sv
// Push-button tune player: debounces a held key, then steps through a fixed
// five-note ROM, emitting MIDI note numbers with silent gaps between notes.
module tune_player #(
    parameter int unsigned TICK_DIV  = 120000,
    parameter int unsigned DEB_TICKS = 3,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic       clk12MHz,
    input  logic       resetn,
    input  logic       key,
    output logic [7:0] midi,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StArm, StNote, StGap, StRelease} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            ks1_q, ks_q;
    logic [1:0]      vld_q;
    logic            armed_q, armed_d;
    logic [7:0]      midi_q, midi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic [7:0]      note_c, dur_c, dur_eff;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        note_c = 8'd0;
        dur_c  = 8'd1;
        unique case (idx_q)
            3'd0:    begin note_c = 8'd74; dur_c = 8'd40;  end
            3'd1:    begin note_c = 8'd76; dur_c = 8'd40;  end
            3'd2:    begin note_c = 8'd72; dur_c = 8'd40;  end
            3'd3:    begin note_c = 8'd60; dur_c = 8'd60;  end
            3'd4:    begin note_c = 8'd67; dur_c = 8'd120; end
            default: begin note_c = 8'd0;  dur_c = 8'd1;   end
        endcase
    end

    assign dur_eff = (dur_c == 8'd0) ? 8'd1 : dur_c;

    // A press only counts once ks has shown a genuine high sample since reset,
    // so a key already held through reset cannot start playback.
    assign armed_d = armed_q | (vld_q[1] & ks_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (!ks_q && armed_q) state_d = StArm;
            end
            StArm: begin
                if (ks_q) begin
                    state_d = StIdle;
                end else if (tick && cnt_q == 8'(DEB_TICKS - 1)) begin
                    state_d = StNote;
                    idx_d   = 3'd0;
                end
            end
            StNote: begin
                if (tick && cnt_q == dur_eff - 8'd1) state_d = StGap;
            end
            StGap: begin
                if (tick && cnt_q == 8'(GAP_TICKS - 1)) begin
                    if (idx_q == 3'd4) begin
                        state_d = StRelease;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StNote;
                    end
                end
            end
            StRelease: begin
                if (ks_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            cnt_d   = 8'd0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        end

        midi_d = (state_q == StNote) ? note_c : 8'd0;
        busy_d = (state_q == StNote) || (state_q == StGap);
        // busy_q is still high only in the first cycle spent in RELEASE.
        done_d = (state_q == StRelease) && busy_q;
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            ks1_q   <= 1'b1;
            ks_q    <= 1'b1;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            state_q <= StIdle;
            idx_q   <= 3'd0;
            presc_q <= '0;
            cnt_q   <= 8'd0;
            midi_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ks1_q   <= key;
            ks_q    <= ks1_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            midi_q  <= midi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign midi = midi_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tune_player.sv
// Randomized bench for tune_player: presses, glitches, key noise during play
// and mid-tune resets, compared against a timeline model of the tune.
module tb_tune_player;

    localparam int unsigned TICK = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned GAP  = 2;
    // Edges from the key falling until midi first shows the first note.
    localparam int LEAD = 2 + 1 + DEB * TICK + 1;

    logic       clk12MHz;
    logic       resetn;
    logic       key;
    logic [7:0] midi;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int notes[5] = '{74, 76, 72, 60, 67};
    int durs[5]  = '{40, 40, 40, 60, 120};

    tune_player #(
        .TICK_DIV (TICK),
        .DEB_TICKS(DEB),
        .GAP_TICKS(GAP)
    ) dut (
        .clk12MHz(clk12MHz),
        .resetn  (resetn),
        .key     (key),
        .midi    (midi),
        .busy    (busy),
        .done    (done)
    );

    initial clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int total_play();
        int t = 0;
        for (int i = 0; i < 5; i++) t += durs[i] * TICK + GAP * TICK;
        return t;
    endfunction

    // Expected midi n clock edges after the key was driven low.
    function automatic int exp_midi(input int n);
        int t;
        if (n < LEAD) return 0;
        t = n - LEAD;
        for (int i = 0; i < 5; i++) begin
            if (t < durs[i] * TICK) return notes[i];
            t -= durs[i] * TICK;
            if (t < GAP * TICK) return 0;
            t -= GAP * TICK;
        end
        return 0;
    endfunction

    function automatic int exp_busy(input int n);
        return (n >= LEAD && n < LEAD + total_play()) ? 1 : 0;
    endfunction

    function automatic int exp_done(input int n);
        return (n == LEAD + total_play()) ? 1 : 0;
    endfunction

    task automatic idle_high(input int cycles);
        key = 1'b1;
        repeat (cycles) @(negedge clk12MHz);
    endtask

    task automatic press();
        @(posedge clk12MHz);
        #1 key = 1'b0;
    endtask

    // One clock of a play: key noise allowed once debounce is long over and
    // stopped well before the end so RELEASE sees a steady key.
    task automatic play_step(input int n, input logic final_key, input int trial);
        @(posedge clk12MHz);
        #1;
        if (n >= 20 && n < 1200) key = 1'($urandom_range(0, 1));
        else if (n == 1200) key = final_key;
        @(negedge clk12MHz);
        check_eq($sformatf("t%0d midi n=%0d", trial, n), 32'(midi), 32'(exp_midi(n)));
        check_eq($sformatf("t%0d busy n=%0d", trial, n), 32'(busy), 32'(exp_busy(n)));
        check_eq($sformatf("t%0d done n=%0d", trial, n), 32'(done), 32'(exp_done(n)));
    endtask

    task automatic play_trial(input int trial);
        logic final_key;
        final_key = 1'($urandom_range(0, 1));
        press();
        for (int n = 1; n <= 1400; n++) play_step(n, final_key, trial);
        idle_high(12);
    endtask

    task automatic glitch_trial(input int trial);
        int len;
        len = $urandom_range(1, 12);
        press();
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk12MHz);
            #1;
            if (n == len) key = 1'b1;
            @(negedge clk12MHz);
            check_eq($sformatf("t%0d glitch%0d midi n=%0d", trial, len, n), 32'(midi), 32'd0);
            check_eq($sformatf("t%0d glitch%0d busy n=%0d", trial, len, n), 32'(busy), 32'd0);
        end
        idle_high(4);
    endtask

    task automatic reset_trial(input int trial);
        int r;
        // Somewhere inside the third note (72).
        r = $urandom_range(LEAD + 2 * (40 * TICK + GAP * TICK),
                           LEAD + 2 * (40 * TICK + GAP * TICK) + 40 * TICK - 1);
        press();
        for (int n = 1; n <= r; n++) play_step(n, 1'b0, trial);
        key = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check_eq($sformatf("t%0d async midi", trial), 32'(midi), 32'd0);
        check_eq($sformatf("t%0d async busy", trial), 32'(busy), 32'd0);
        check_eq($sformatf("t%0d async done", trial), 32'(done), 32'd0);
        repeat (3) @(negedge clk12MHz);
        resetn = 1'b1;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk12MHz);
            check_eq($sformatf("t%0d held midi n=%0d", trial, n), 32'(midi), 32'd0);
            check_eq($sformatf("t%0d held busy n=%0d", trial, n), 32'(busy), 32'd0);
        end
        idle_high(12);
    endtask

    initial begin
        int kind;
        key    = 1'b1;
        resetn = 1'b0;
        #12;
        check_eq("reset midi", 32'(midi), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        @(negedge clk12MHz);
        resetn = 1'b1;
        idle_high(10);
        check_eq("idle midi", 32'(midi), 32'd0);

        for (int i = 0; i < 8; i++) begin
            kind = (i < 3) ? i : int'($urandom_range(0, 2));
            case (kind)
                0:       play_trial(i);
                1:       glitch_trial(i);
                default: reset_trial(i);
            endcase
        end
        play_trial(99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tune_player.md
TUNE_PLAYER -- requirements
Module: tune_player

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 120000, meaning clk12MHz cycles per tick (10 ms at 12 MHz), legal range 2..2^17.
REQ-002 The module SHALL have parameter DEB_TICKS, default 3, meaning the number of ticks key must stay low before playback starts, legal range 1..255.
REQ-003 The module SHALL have parameter GAP_TICKS, default 2, meaning silent ticks after each note, legal range 1..255.
REQ-004 The module SHALL have port clk12MHz, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port key, input, 1 bit: asynchronous push-button, active-low (pressed = 0).
REQ-007 The module SHALL have port midi, output, 8 bits, registered: the current MIDI note number, where 0 means silence; it feeds the tone generator.
REQ-008 The module SHALL have port busy, output, 1 bit, registered: high while a tune is playing (NOTE or GAP state).
REQ-009 The module SHALL have port done, output, 1 bit, registered: a 1-cycle pulse when the last gap completes.

Function
REQ-010 key SHALL pass through a 2-flop synchronizer (reset value 1); the state machine SHALL use only the synchronized value ks.
REQ-011 A prescaler SHALL count 0..TICK_DIV-1; tick SHALL be 1 for exactly the cycle in which the prescaler equals TICK_DIV-1, and the prescaler SHALL then wrap to 0.
REQ-012 The prescaler and the tick counter SHALL clear to 0 on every state transition, so that a state lasting N ticks lasts exactly N*TICK_DIV cycles.
REQ-013 The tune table SHALL be a fixed 5-entry ROM of {note, duration in ticks}: 0:{74,40}, 1:{76,40}, 2:{72,40}, 3:{60,60}, 4:{67,120}; the index is 3 bits wide.
REQ-014 The state machine SHALL have exactly the states IDLE, ARM, NOTE, GAP and RELEASE.
REQ-015 IDLE: when ks = 0, the state SHALL go to ARM; otherwise it stays in IDLE.
REQ-016 ARM: if ks = 1, the state SHALL return to IDLE; after DEB_TICKS ticks with ks = 0 continuously, the state SHALL go to NOTE with index 0.
REQ-017 NOTE: after the duration of table[index] ticks, the state SHALL go to GAP; a duration of 0 SHALL be treated as 1.
REQ-018 GAP: after GAP_TICKS ticks, if index < 4 the index SHALL increment and the state SHALL go to NOTE; if index = 4 the state SHALL go to RELEASE and done SHALL pulse.
REQ-019 RELEASE: the state SHALL wait for ks = 1, then go to IDLE; holding the key therefore never retriggers playback.
REQ-020 midi SHALL equal table[index].note starting the cycle after NOTE is entered, and SHALL be 0 starting the cycle after any other state is entered.
REQ-021 busy SHALL be 1 starting the cycle after NOTE is entered and SHALL fall the cycle after RELEASE is entered.
REQ-022 done SHALL be 1 for exactly the single cycle after RELEASE is entered.
REQ-023 key activity during NOTE or GAP SHALL be ignored.
REQ-024 A glitch on key shorter than DEB_TICKS ticks SHALL produce no playback.

Reset
REQ-025 While resetn = 0, the outputs SHALL be forced asynchronously to midi = 0, busy = 0 and done = 0.
REQ-026 While resetn = 0, the internal values SHALL be forced asynchronously to state IDLE, index 0, prescaler 0, tick counter 0 and synchronizer flops 1.
REQ-027 A reset asserted during playback SHALL silence midi on the same edge of resetn, without waiting for a clock edge.
REQ-028 After reset deasserts, a new press SHALL be required to start playback, even if key is still held low.

Verification (TICK_DIV=4, DEB_TICKS=3, GAP_TICKS=2)
REQ-029 Scenario: key held low from idle -> midi = 74 appears 2 (sync) + 1 + 12 + 1 cycles after the key falls; the note lasts 160 cycles; it is followed by 8 cycles of midi = 0, then midi = 76.
REQ-030 Scenario: full tune -> midi sequence 74, 0, 76, 0, 72, 0, 60, 0, 67, 0; busy high throughout; done pulses once for exactly 1 cycle; total busy time 1200 + 40 cycles.
REQ-031 Scenario: key low for 8 cycles then high -> midi stays 0, busy stays 0, and the state returns to IDLE.
REQ-032 Scenario: key held low after done -> no second play; releasing and pressing again -> the tune restarts at 74.
REQ-033 Scenario: resetn pulsed low mid-note 72 -> midi = 0 and busy = 0 immediately (asynchronously); after release of reset, no playback occurs until a new press.
REQ-034 Scenario: key toggled during a GAP -> the note sequence and its timing are unchanged.
